mul_product_accumulator: RTL and testbench



---
 rtl/mul_acc_pkg.sv | 33 +++
 rtl/mul_acc_adder.sv | 31 +++
 rtl/mul_product_accumulator.sv | 145 ++++++++++++++
 tb/tb_mul_product_accumulator.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mul_acc_pkg.sv
// Shared types and helpers for the multiplier product accumulator.
// The saturating add is exercised only when MUL_ACC_SATURATE_EN is defined.
package mul_acc_pkg;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_e;

  localparam int CNT_WIDTH = 8;
  localparam int SAT_MAX_W = 128;
  localparam int SAT_IDX_W = 7;

  // Signed add of two w-bit values (sign-extended to SAT_MAX_W); returns {sum, ovf}
  // with the sum clamped to the w-bit signed range when the add overflows.
  function automatic logic [SAT_MAX_W:0] sat_add(
    input logic [SAT_MAX_W-1:0] a,
    input logic [SAT_MAX_W-1:0] b,
    input logic [SAT_IDX_W-1:0] w
  );
    logic [SAT_MAX_W-1:0] sum;
    logic [SAT_MAX_W-1:0] max_pos;
    logic                 ovf;
    sum     = a + b;
    max_pos = ({{(SAT_MAX_W-1){1'b0}}, 1'b1} << (w - 7'd1)) - {{(SAT_MAX_W-1){1'b0}}, 1'b1};
    ovf     = (a[w-7'd1] == b[w-7'd1]) && (sum[w-7'd1] != a[w-7'd1]);
    if (ovf) begin
      sum = a[w-7'd1] ? ~max_pos : max_pos;
    end
    return {sum, ovf};
  endfunction

endpackage

// File: rtl/mul_acc_adder.sv
// Combinational sign-extend + add for the accumulator; clamps on signed
// overflow when MUL_ACC_SATURATE_EN is defined, otherwise wraps.
module mul_acc_adder
  import mul_acc_pkg::*;
#(
  parameter int RESULT_WIDTH = 32,
  parameter int ACC_WIDTH    = 40
) (
  input  logic [ACC_WIDTH-1:0]    acc_i,
  input  logic [RESULT_WIDTH-1:0] product_i,
  output logic [ACC_WIDTH-1:0]    sum_o,
  output logic                    ovf_o
);

  logic [ACC_WIDTH-1:0] prod_ext_s;

  assign prod_ext_s = ACC_WIDTH'($signed(product_i));

`ifdef MUL_ACC_SATURATE_EN
  logic [SAT_MAX_W:0] res_s;

  assign res_s = sat_add(SAT_MAX_W'($signed(acc_i)), SAT_MAX_W'($signed(prod_ext_s)),
                         SAT_IDX_W'(ACC_WIDTH));
  assign sum_o = res_s[ACC_WIDTH:1];
  assign ovf_o = res_s[0];
`else
  assign sum_o = acc_i + prod_ext_s;
  assign ovf_o = 1'b0;
`endif

endmodule

// File: rtl/mul_product_accumulator.sv
// Sums NUM_TERMS signed products (fewer on flush) and holds the sum until taken.
// Optional clamping on overflow: define MUL_ACC_SATURATE_EN.
module mul_product_accumulator
  import mul_acc_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int RESULT_WIDTH = 32,
  parameter int ACC_WIDTH    = 40,
  parameter int NUM_TERMS    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [RESULT_WIDTH-1:0] in_product,
  output logic                    in_ready,
  input  logic                    flush,
  output logic                    out_valid,
  output logic [ACC_WIDTH-1:0]    out_sum,
  output logic [CNT_WIDTH-1:0]    out_terms,
  output logic                    out_sat,
  input  logic                    out_ready
);

  generate
    if (RESULT_WIDTH != 2 * WIDTH || ACC_WIDTH < RESULT_WIDTH || ACC_WIDTH >= SAT_MAX_W ||
        NUM_TERMS < 1 || NUM_TERMS > 255) begin : g_bad_params
      $error("mul_product_accumulator: inconsistent parameters");
    end
  endgenerate

  acc_state_e           state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 sat_q, sat_d;
  logic                 out_valid_q, out_valid_d;
  logic [ACC_WIDTH-1:0] out_sum_q, out_sum_d;
  logic [CNT_WIDTH-1:0] out_terms_q, out_terms_d;
  logic                 out_sat_q, out_sat_d;

  logic [ACC_WIDTH-1:0] add_sum_s;
  logic                 add_ovf_s;
  logic                 accept_s;
  logic [CNT_WIDTH-1:0] cnt_inc_s;

  mul_acc_adder #(
    .RESULT_WIDTH (RESULT_WIDTH),
    .ACC_WIDTH    (ACC_WIDTH)
  ) u_adder (
    .acc_i     (acc_q),
    .product_i (in_product),
    .sum_o     (add_sum_s),
    .ovf_o     (add_ovf_s)
  );

  // in_ready is forced low while reset is held so no product leaks into a discarded sum
  assign in_ready  = (state_q == ACCUM) && reset;
  assign accept_s  = in_valid && in_ready;
  assign cnt_inc_s = cnt_q + 8'd1;

  // Next-state, accumulation and output-capture logic
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_terms_d = out_terms_q;
    out_sat_d   = out_sat_q;
    case (state_q)
      ACCUM: begin
        out_valid_d = 1'b0;
        if (accept_s) begin
          acc_d = add_sum_s;
          cnt_d = cnt_inc_s;
          sat_d = sat_q | add_ovf_s;
          if (cnt_inc_s == CNT_WIDTH'(NUM_TERMS) || flush) begin
            out_sum_d   = add_sum_s;
            out_terms_d = cnt_inc_s;
            out_sat_d   = sat_q | add_ovf_s;
            out_valid_d = 1'b1;
            state_d     = HOLD;
          end else begin
            state_d = ACCUM;
          end
        end else if (flush && cnt_q != 8'd0) begin
          out_sum_d   = acc_q;
          out_terms_d = cnt_q;
          out_sat_d   = sat_q;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end else begin
          state_d = ACCUM;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = '0;
          cnt_d       = 8'd0;
          sat_d       = 1'b0;
          state_d     = ACCUM;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        acc_d       = '0;
        cnt_d       = 8'd0;
        sat_d       = 1'b0;
        state_d     = ACCUM;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= 8'd0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_terms_q <= 8'd0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_terms_q <= out_terms_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_terms = out_terms_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_mul_product_accumulator.sv
// Randomized + directed bench for mul_product_accumulator against a
// transaction-level model (running integer sum, term count, hold flag).
module tb_mul_product_accumulator;

  localparam int ACC_W = 40;
  localparam int NT    = 4;

  logic        clk = 1'b0;
  logic        reset, in_valid, flush, out_ready, in_ready, out_valid, out_sat;
  logic [31:0] in_product;
  logic [39:0] out_sum;
  logic [7:0]  out_terms;

  logic        v33, rdy33, valid33, sat33;
  logic [31:0] p33;
  logic [32:0] sum33;
  logic [7:0]  terms33;

  int vectors = 0;
  int errors  = 0;

  // Model state
  bit     m_hold, m_after_reset, m_sat, m_out_sat;
  longint m_acc, m_out_sum;
  int     m_n, m_out_terms;

  always #5 clk = ~clk;

  mul_product_accumulator #(.WIDTH(16), .RESULT_WIDTH(32), .ACC_WIDTH(ACC_W), .NUM_TERMS(NT)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_product(in_product), .in_ready(in_ready),
    .flush(flush), .out_valid(out_valid), .out_sum(out_sum), .out_terms(out_terms),
    .out_sat(out_sat), .out_ready(out_ready)
  );

  mul_product_accumulator #(.WIDTH(16), .RESULT_WIDTH(32), .ACC_WIDTH(33), .NUM_TERMS(NT)) dut33 (
    .clk(clk), .reset(reset), .in_valid(v33), .in_product(p33), .in_ready(rdy33),
    .flush(1'b0), .out_valid(valid33), .out_sum(sum33), .out_terms(terms33),
    .out_sat(sat33), .out_ready(1'b1)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint model_add(input longint s, input longint p, input int w, inout bit sat);
    longint r, mx, mn;
    r  = s + p;
    mx = (longint'(1) <<< (w - 1)) - 1;
    mn = -mx - 1;
`ifdef MUL_ACC_SATURATE_EN
    if (r > mx) begin r = mx; sat = 1'b1; end
    else if (r < mn) begin r = mn; sat = 1'b1; end
`else
    if (mx < mn) sat = 1'b1;
`endif
    return r;
  endfunction

  function automatic logic [63:0] low_bits(input longint s, input int w);
    logic [63:0] t;
    t = s;
    return t & ((64'd1 << w) - 64'd1);
  endfunction

  // One clock: apply inputs, advance the model over the coming edge, check at the next negedge
  task automatic drive(input bit v, input logic [31:0] p, input bit f, input bit r, input bit rst);
    bit took;
    reset = rst; in_valid = v; in_product = p; flush = f; out_ready = r;
    if (!rst) begin
      m_hold = 0; m_acc = 0; m_n = 0; m_sat = 0;
      m_out_sum = 0; m_out_terms = 0; m_out_sat = 0; m_after_reset = 1;
    end else if (!m_hold) begin
      took = v;
      if (took) begin
        m_acc = model_add(m_acc, longint'($signed(p)), ACC_W, m_sat);
        m_n++;
      end
      if ((took && (m_n == NT || f)) || (!took && f && m_n > 0)) begin
        m_hold = 1; m_out_sum = m_acc; m_out_terms = m_n; m_out_sat = m_sat; m_after_reset = 0;
      end
    end else if (r) begin
      m_hold = 0; m_acc = 0; m_n = 0; m_sat = 0;
    end
    @(negedge clk);
    check_eq("in_ready", 64'(in_ready), 64'(!m_hold && reset));
    check_eq("out_valid", 64'(out_valid), 64'(m_hold));
    if (m_hold || m_after_reset) begin
      check_eq("out_sum", 64'(out_sum), low_bits(m_out_sum, ACC_W));
      check_eq("out_terms", 64'(out_terms), 64'(m_out_terms));
      check_eq("out_sat", 64'(out_sat), 64'(m_out_sat));
    end
  endtask

  initial begin
    logic [31:0] p;
    longint      s33;
    bit          sat33_m;
    v33 = 0; p33 = 32'h0;
    reset = 0; in_valid = 0; in_product = 32'h0; flush = 0; out_ready = 0;
    m_hold = 0; m_after_reset = 1; m_sat = 0; m_out_sat = 0;
    m_acc = 0; m_out_sum = 0; m_n = 0; m_out_terms = 0;

    drive(0, 32'h0, 0, 0, 0);
    drive(0, 32'h0, 0, 0, 0);
    check_eq("rdy33_reset", 64'(rdy33), 64'd0);
    drive(0, 32'h0, 0, 1, 1);

    // Four products back-to-back: 3 + 5 - 2 + 10
    drive(1, 32'd3, 0, 1, 1);
    drive(1, 32'd5, 0, 1, 1);
    drive(1, -32'sd2, 0, 1, 1);
    drive(1, 32'd10, 0, 1, 1);
    check_eq("plan_sum16", 64'(out_sum), 64'd16);
    drive(0, 32'h0, 0, 1, 1);

    // 7, 9 then flush
    drive(1, 32'd7, 0, 1, 1);
    drive(1, 32'd9, 0, 1, 1);
    drive(0, 32'h0, 1, 0, 1);
    check_eq("plan_flush_terms", 64'(out_terms), 64'd2);
    drive(0, 32'h0, 0, 1, 1);

    // Flush together with the only product
    drive(1, 32'd4, 1, 0, 1);
    drive(0, 32'h0, 0, 1, 1);

    // Flush with nothing accumulated
    drive(0, 32'h0, 1, 1, 1);
    drive(0, 32'h0, 1, 1, 1);

    // Back-pressure: sum held for 5 cycles while a product waits
    for (int i = 0; i < 4; i++) drive(1, 32'(i + 1), 0, 0, 1);
    for (int i = 0; i < 5; i++) drive(1, 32'd123, 0, 0, 1);
    drive(1, 32'd123, 0, 1, 1);
    drive(1, 32'd123, 0, 1, 1);
    for (int i = 0; i < 3; i++) drive(1, 32'd1, 0, 1, 1);
    drive(0, 32'h0, 0, 1, 1);

    // Reset mid-sum
    drive(1, 32'd50, 0, 1, 1);
    drive(1, 32'd60, 0, 1, 1);
    drive(1, 32'd55, 0, 1, 0);
    for (int i = 0; i < 4; i++) drive(1, 32'(i + 20), 0, 1, 1);
    drive(0, 32'h0, 0, 1, 1);

    // 33-bit accumulator fed 0x7FFFFFFF four times
    s33 = 0; sat33_m = 0;
    for (int i = 0; i < 4; i++) s33 = model_add(s33, 64'h7FFFFFFF, 33, sat33_m);
    v33 = 1; p33 = 32'h7FFFFFFF;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        reset = 1; in_valid = 0; flush = 0; out_ready = 1;
        @(posedge clk);
        #1 v33 = 0;
        @(negedge clk);
      end else begin
        drive(0, 32'h0, 0, 1, 1);
      end
    end
    check_eq("w33_valid", 64'(valid33), 64'd1);
    check_eq("w33_sum", 64'(sum33), low_bits(s33, 33));
    check_eq("w33_terms", 64'(terms33), 64'd4);
    check_eq("w33_sat", 64'(sat33), 64'(sat33_m));
    drive(0, 32'h0, 0, 1, 1);
    check_eq("w33_released", 64'(valid33), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      p = $urandom;
      case ($urandom_range(7, 0))
        0: p = 32'h7FFFFFFF;
        1: p = 32'h80000000;
        default: p = p;
      endcase
      drive($urandom_range(9, 0) < 7, p, $urandom_range(9, 0) == 0,
            $urandom_range(9, 0) < 6, $urandom_range(99, 0) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
